// File: rtl/reorder_commit_pkg.sv
// Shared definitions for the reorder/commit block: rename widths, dispatch
// record field layout and the commit FSM state encoding.
package reorder_commit_pkg;

  localparam int unsigned RNBIT           = 2;
  localparam int unsigned RNDEPTH         = 2 ** RNBIT;
  localparam int unsigned RD_W            = 5 + RNBIT;
  localparam int unsigned REORDER_INFO_DW = 64 + RD_W + 3;

  // dispat_info layout, MSB first: {pc, rd0_reName, isBranch, isSu, isCsr}
  localparam int unsigned InfoIsCsrBit    = 0;
  localparam int unsigned InfoIsSuBit     = 1;
  localparam int unsigned InfoIsBranchBit = 2;
  localparam int unsigned InfoRdLsb       = 3;
  localparam int unsigned InfoRdMsb       = InfoRdLsb + RD_W - 1;
  localparam int unsigned InfoPcLsb       = InfoRdMsb + 1;
  localparam int unsigned InfoPcMsb       = InfoPcLsb + 63;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } rob_state_e;

  // Architectural register index carried in the upper bits of a renamed rd.
  function automatic logic [4:0] rd_arch(input logic [RD_W-1:0] rd);
    return rd[RD_W-1 -: 5];
  endfunction

endpackage

// File: rtl/reorder_ring.sv
// Circular entry store for the reorder buffer: push at tail, pop at head,
// synchronous clear, and full/empty from wrap-bit pointers.
module reorder_ring #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             head_valid_o,
  output logic [Width-1:0] head_data_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      head_q, tail_q;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok;

  assign full_o       = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign empty_o      = (head_q == tail_q);
  assign push_ok      = push_i & ~full_o;
  assign head_valid_o = valid_q[head_q[AW-1:0]];
  assign head_data_o  = mem_q[head_q[AW-1:0]];

  // Next valid bits: set on push, clear on pop.
  always_comb begin
    valid_d = valid_q;
    if (push_ok) valid_d[tail_q[AW-1:0]] = 1'b1;
    if (pop_i)   valid_d[head_q[AW-1:0]] = 1'b0;
  end

  // Pointers and valid bits; clear empties the ring back to index 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_ok) tail_q <= tail_q + PtrOne;
      if (pop_i)   head_q <= head_q + PtrOne;
    end
  end

  // Entry payload; no reset needed, qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[tail_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/reorder_commit.sv
// In-order reorder buffer and commit stage. Retires the head record once its
// destination is written back (or its branch resolves) and requests a
// one-cycle pipeline flush after a mispredicted branch commits.
// Optional retire counter output enabled by defining REORDER_INSTRET_EN.
module reorder_commit
  import reorder_commit_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [REORDER_INFO_DW-1:0] dispat_info,
  input  logic                       reOrder_fifo_push,
  output logic                       reOrder_fifo_full,
  input  logic [32*RNDEPTH-1:0]      wbLog_qout,
  input  logic                       bru_res_vaild,
  input  logic                       bru_mispredict,
  output logic                       commit_vaild,
  output logic [63:0]                commit_pc,
  output logic [RD_W-1:0]            commit_rd0,
  output logic                       commit_wr,
  output logic                       su_commit,
  output logic                       flush
`ifdef REORDER_INSTRET_EN
  ,
  output logic [63:0]                instret
`endif
);

  rob_state_e                 state_q;
  logic                       resolved_q, mispred_q, flush_q;
  logic                       ring_full, ring_empty, head_valid;
  logic [REORDER_INFO_DW-1:0] head_info;
  logic                       push_ok, retire, head_ready, head_mispredict;
  logic                       head_is_br, head_is_su;
  logic [RD_W-1:0]            head_rd;
  logic [63:0]                head_pc;
  logic [4:0]                 head_arch;
  logic                       unused_csr;

  assign head_pc    = head_info[InfoPcMsb:InfoPcLsb];
  assign head_rd    = head_info[InfoRdMsb:InfoRdLsb];
  assign head_is_br = head_info[InfoIsBranchBit];
  assign head_is_su = head_info[InfoIsSuBit];
  assign head_arch  = rd_arch(head_rd);
  assign unused_csr = head_info[InfoIsCsrBit];

  assign push_ok = reOrder_fifo_push & ~ring_full & (state_q == StRun);

  reorder_ring #(
    .Depth(DEPTH),
    .Width(REORDER_INFO_DW)
  ) u_ring (
    .clk_i       (CLK),
    .rst_ni      (RSTn),
    .push_i      (push_ok),
    .data_i      (dispat_info),
    .pop_i       (retire),
    .clear_i     (state_q == StFlush),
    .full_o      (ring_full),
    .empty_o     (ring_empty),
    .head_valid_o(head_valid),
    .head_data_o (head_info)
  );

  // Head readiness: branches wait for resolution, stores and x0 writers
  // go immediately, everything else waits for its written-back flag.
  always_comb begin
    head_ready = 1'b0;
    if (head_valid && !ring_empty) begin
      if (head_is_br) begin
        head_ready = bru_res_vaild | resolved_q;
      end else if (head_is_su || head_arch == 5'd0) begin
        head_ready = 1'b1;
      end else begin
        head_ready = wbLog_qout[head_rd];
      end
    end
  end

  // A latched resolution belongs to the head branch; otherwise use this cycle's.
  assign head_mispredict = resolved_q ? mispred_q : bru_mispredict;
  assign retire          = head_ready & (state_q == StRun);

  // Commit outputs are driven only while the head actually retires.
  always_comb begin
    commit_vaild = retire;
    commit_pc    = retire ? head_pc : 64'd0;
    commit_rd0   = retire ? head_rd : '0;
    commit_wr    = retire & (head_arch != 5'd0);
    su_commit    = retire & head_is_su;
  end

  assign reOrder_fifo_full = ring_full;
  assign flush             = flush_q;

  // Commit FSM with the latched branch-resolution flag and registered flush.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StRun;
      resolved_q <= 1'b0;
      mispred_q  <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (retire && head_is_br) begin
            // A latched outcome was consumed; a new resolution this cycle is
            // for the next younger branch.
            if (resolved_q && bru_res_vaild) begin
              resolved_q <= 1'b1;
              mispred_q  <= bru_mispredict;
            end else begin
              resolved_q <= 1'b0;
              mispred_q  <= 1'b0;
            end
            if (head_mispredict) begin
              state_q <= StFlush;
              flush_q <= 1'b1;
            end
          end else if (bru_res_vaild) begin
            resolved_q <= 1'b1;
            mispred_q  <= bru_mispredict;
          end
        end
        StFlush: begin
          state_q    <= StRun;
          flush_q    <= 1'b0;
          resolved_q <= 1'b0;
          mispred_q  <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef REORDER_INSTRET_EN
  // Retired-instruction counter; wraps naturally.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      instret <= 64'd0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_commit.sv
// Self-checking bench for reorder_commit: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_reorder_commit;
  import reorder_commit_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 74;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [IW-1:0]   dispat_info;
  logic            push;
  logic            full;
  logic [127:0]    wb;
  logic            bru, mis;
  logic            c_vaild;
  logic [63:0]     c_pc;
  logic [6:0]      c_rd0;
  logic            c_wr, su_c, flush;
  logic [63:0]     instret_v;

  int n_checks = 0;
  int n_pass   = 0;

  reorder_commit #(.DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .dispat_info      (dispat_info),
    .reOrder_fifo_push(push),
    .reOrder_fifo_full(full),
    .wbLog_qout       (wb),
    .bru_res_vaild    (bru),
    .bru_mispredict   (mis),
    .commit_vaild     (c_vaild),
    .commit_pc        (c_pc),
    .commit_rd0       (c_rd0),
    .commit_wr        (c_wr),
    .su_commit        (su_c),
    .flush            (flush)
`ifdef REORDER_INSTRET_EN
    ,
    .instret          (instret_v)
`endif
  );

`ifndef REORDER_INSTRET_EN
  assign instret_v = 64'd0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [IW-1:0] mk(input logic [63:0] pc, input logic [4:0] arch,
                                       input logic [1:0] cp, input logic br,
                                       input logic su, input logic csr);
    return {pc, arch, cp, br, su, csr};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [IW-1:0] mq[$];     // in-flight records, oldest first
  logic          outc[$];   // resolved-but-not-retired branch outcomes
  logic          m_flush = 1'b0;
  logic [63:0]   m_instret = 64'd0;
  logic [IW-1:0] h;
  logic          m_ret, m_mis, m_used_bru, m_full_pre;

  always @(negedge CLK) begin
    if (!RSTn) begin
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_vaild", 64'(c_vaild), 64'd0);
      chk("rst_pc", c_pc, 64'd0);
      chk("rst_rd0", 64'(c_rd0), 64'd0);
      chk("rst_wr", 64'(c_wr), 64'd0);
      chk("rst_su", 64'(su_c), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
`ifdef REORDER_INSTRET_EN
      chk("rst_instret", instret_v, 64'd0);
`endif
      mq.delete();
      outc.delete();
      m_flush   = 1'b0;
      m_instret = 64'd0;
    end else begin
      m_ret = 1'b0;
      m_mis = 1'b0;
      h     = '0;
      if (!m_flush && mq.size() > 0) begin
        h = mq[0];
        if (h[2]) begin
          if (outc.size() > 0) begin
            m_ret = 1'b1;
            m_mis = outc[0];
          end else if (bru) begin
            m_ret = 1'b1;
            m_mis = mis;
          end
        end else if (h[1] || h[9:5] == 5'd0) begin
          m_ret = 1'b1;
        end else begin
          m_ret = wb[h[9:3]];
        end
      end
      chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
      chk("m_flush", 64'(flush), 64'(m_flush));
      chk("m_vaild", 64'(c_vaild), 64'(m_ret));
      chk("m_wr", 64'(c_wr), 64'(m_ret && h[9:5] != 5'd0));
      chk("m_su", 64'(su_c), 64'(m_ret && h[1]));
      if (m_ret) begin
        chk("m_pc", c_pc, h[73:10]);
        chk("m_rd0", 64'(c_rd0), 64'(h[9:3]));
      end
`ifdef REORDER_INSTRET_EN
      chk("m_instret", instret_v, m_instret);
`endif
      // Advance the model to what the coming edge must do.
      if (m_flush) begin
        mq.delete();
        outc.delete();
        m_flush = 1'b0;
      end else begin
        m_full_pre = (mq.size() == DEPTH);
        m_used_bru = 1'b0;
        if (m_ret) begin
          if (h[2]) begin
            if (outc.size() > 0) void'(outc.pop_front());
            else m_used_bru = 1'b1;
            if (m_mis) m_flush = 1'b1;
          end
          void'(mq.pop_front());
          m_instret = m_instret + 64'd1;
        end
        if (bru && !m_used_bru) outc.push_back(mis);
        if (push && !m_full_pre) mq.push_back(dispat_info);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    RSTn = 1'b0; push = 1'b0; dispat_info = '0; wb = '0; bru = 1'b0; mis = 1'b0;
    repeat (3) step();
    chk("lit_rst_full", 64'(full), 64'd0);
    chk("lit_rst_flush", 64'(flush), 64'd0);
    RSTn = 1'b1;
    step();

    // Simple ALU op writing x3 copy 1 (physical index 13)
    wb = 128'd1 << 13;
    push = 1'b1; dispat_info = mk(64'h8000_0000, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    push = 1'b0;
    #2;
    chk("lit_t1_vaild", 64'(c_vaild), 64'd1);
    chk("lit_t1_pc", c_pc, 64'h8000_0000);
    chk("lit_t1_rd0", 64'(c_rd0), 64'h0D);
    chk("lit_t1_wr", 64'(c_wr), 64'd1);
    chk("lit_t1_su", 64'(su_c), 64'd0);
    step();
    wb = '0;

    // Store retires without any written-back flag
    push = 1'b1; dispat_info = mk(64'h8000_0004, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    push = 1'b0;
    #2;
    chk("lit_t2_vaild", 64'(c_vaild), 64'd1);
    chk("lit_t2_su", 64'(su_c), 64'd1);
    chk("lit_t2_wr", 64'(c_wr), 64'd0);
    step();

    // Fill to full, drop a 9th push, then drain in order
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; dispat_info = mk(64'h1000 + 64'(4 * i), 5'(i + 1), 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    dispat_info = mk(64'hdead, 5'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lit_t3_full", 64'(full), 64'd1);
    step();
    push = 1'b0;
    wb = '1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("lit_t3_pc", c_pc, 64'h1000 + 64'(4 * i));
      step();
    end
    #2;
    chk("lit_t3_drained", 64'(c_vaild), 64'd0);
    chk("lit_t3_notfull", 64'(full), 64'd0);
    step();

    // Second fill crosses the pointer wrap
    wb = '0;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; dispat_info = mk(64'h2000 + 64'(4 * i), 5'(i + 9), 2'd3, 1'b0, 1'b0, 1'b0);
      step();
    end
    push = 1'b0;
    #2;
    chk("lit_t3w_full", 64'(full), 64'd1);
    wb = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lit_t3w_pc", c_pc, 64'h2000 + 64'(4 * i));
      step();
      #1;
    end
    step();

    // Mispredicted branch at head with three younger entries behind it
    push = 1'b1; dispat_info = mk(64'h3000, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 4; i++) begin
      dispat_info = mk(64'h3000 + 64'(4 * i), 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    push = 1'b0;
    bru = 1'b1; mis = 1'b1;
    #2;
    chk("lit_t4_br_vaild", 64'(c_vaild), 64'd1);
    chk("lit_t4_br_pc", c_pc, 64'h3000);
    chk("lit_t4_noflush", 64'(flush), 64'd0);
    step();
    bru = 1'b0; mis = 1'b0;
    push = 1'b1; dispat_info = mk(64'h5555, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("lit_t4_flush", 64'(flush), 64'd1);
    chk("lit_t4_fl_vaild", 64'(c_vaild), 64'd0);
    step();
    push = 1'b0;
    #2;
    chk("lit_t4_flush_off", 64'(flush), 64'd0);
    chk("lit_t4_empty", 64'(c_vaild), 64'd0);
    repeat (3) step();

    // Correctly predicted branch resolved while an older op is pending
    wb = '0;
    push = 1'b1; dispat_info = mk(64'h4000, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    dispat_info = mk(64'h4004, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step();
    push = 1'b0;
    bru = 1'b1; mis = 1'b0;
    step();
    bru = 1'b0;
    step();
    step();
    #2;
    chk("lit_t5_blocked", 64'(c_vaild), 64'd0);
    wb = 128'd1 << 30;
    #1;
    chk("lit_t5_old_pc", c_pc, 64'h4000);
    step();
    #2;
    chk("lit_t5_br_vaild", 64'(c_vaild), 64'd1);
    chk("lit_t5_br_pc", c_pc, 64'h4004);
    chk("lit_t5_noflush", 64'(flush), 64'd0);
    step();
    #2;
    chk("lit_t5_after", 64'(flush), 64'd0);
    step();

    // Five retires from a fresh reset, then asynchronous reset while full
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    wb = '0;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; dispat_info = mk(64'h6000 + 64'(4 * i), 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      step();
    end
    push = 1'b0;
    step();
`ifdef REORDER_INSTRET_EN
    #2;
    chk("lit_t6_instret5", instret_v, 64'd5);
`endif
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; dispat_info = mk(64'h7000 + 64'(4 * i), 5'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    push = 1'b0;
    #2;
    chk("lit_t6_full", 64'(full), 64'd1);
    RSTn = 1'b0;
    #1;
    chk("lit_t6_rst_full", 64'(full), 64'd0);
    chk("lit_t6_rst_vaild", 64'(c_vaild), 64'd0);
`ifdef REORDER_INSTRET_EN
    chk("lit_t6_rst_instret", instret_v, 64'd0);
`endif
    step();
    step();
    RSTn = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
